// File: rtl/image_bit_streamer_pkg.sv
// -----------------------------------------------------------------------------
// image_bit_streamer_pkg
// Shared constants and types for the image bit streamer slice:
//   IMG_CNT   - number of stored test images
//   ROW_W     - pixels per row (rows per image equals ROW_W)
//   IMG_W     - width of an image index
//   ROW_IDX_W - width of a row (or column) index
//   BIT_W     - width of a bit index inside one image (row,column)
//   state_e   - streamer FSM state encoding
// -----------------------------------------------------------------------------
package image_bit_streamer_pkg;

  localparam int IMG_CNT   = 10;
  localparam int ROW_W     = 16;
  localparam int IMG_W     = $clog2(IMG_CNT);
  localparam int ROW_IDX_W = $clog2(ROW_W);
  localparam int BIT_W     = 2 * ROW_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/image_bit_streamer_if.sv
// -----------------------------------------------------------------------------
// image_bit_streamer_if
// Bundles the control, image-load and engine handshake signals of the streamer.
//   master : host/engine side (drives start, wr_*, give_input, output_valid)
//   slave  : streamer side    (drives din, din_valid, cur_img, busy, done)
// -----------------------------------------------------------------------------
interface image_bit_streamer_if #(
  parameter int IMG_W     = 4,
  parameter int ROW_IDX_W = 4,
  parameter int ROW_W     = 16
) ();

  logic                 start;
  logic                 wr_en;
  logic [IMG_W-1:0]     wr_img;
  logic [ROW_IDX_W-1:0] wr_row;
  logic [ROW_W-1:0]     wr_data;
  logic                 give_input;
  logic                 output_valid;
  logic                 din;
  logic                 din_valid;
  logic [IMG_W-1:0]     cur_img;
  logic                 busy;
  logic                 done;

  modport master (
    output start, wr_en, wr_img, wr_row, wr_data, give_input, output_valid,
    input  din, din_valid, cur_img, busy, done
  );

  modport slave (
    input  start, wr_en, wr_img, wr_row, wr_data, give_input, output_valid,
    output din, din_valid, cur_img, busy, done
  );

endinterface

// File: rtl/image_bit_streamer_row_ram.sv
// -----------------------------------------------------------------------------
// image_row_ram
// Image buffer: DEPTH rows of ROW_W bits, one synchronous write port and one
// combinational read port. Contents are never reset.
//   CLOCK_50 - clock
//   wr_en    - write strobe (already qualified by the caller)
//   wr_addr  - write row address {image,row}
//   wr_data  - row pixels, MSB = leftmost
//   rd_addr  - read row address {image,row}
//   rd_data  - row pixels at rd_addr
// -----------------------------------------------------------------------------
module image_row_ram #(
  parameter int DEPTH  = 160,
  parameter int ROW_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ROW_W-1:0]  rd_data
);

  logic [ROW_W-1:0] mem_r [DEPTH];

  // Row write port.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/image_bit_streamer.sv
// -----------------------------------------------------------------------------
// image_bit_streamer
// Streams stored ROW_W x ROW_W binary images one pixel bit at a time to a
// downstream engine. Each give_input pulls the next bit (row 0 first, MSB
// first within a row); after the last bit the streamer waits for the engine's
// output_valid before moving to the next image. After the last image it sits
// in DONE until start is released.
//   CLOCK_50 - clock, rising edge
//   rst      - synchronous, active-low reset (buffer contents are kept)
//   bus      - slave side of image_bit_streamer_if
// -----------------------------------------------------------------------------
module image_bit_streamer #(
  parameter int IMG_CNT = image_bit_streamer_pkg::IMG_CNT,
  parameter int ROW_W   = image_bit_streamer_pkg::ROW_W
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  image_bit_streamer_if.slave bus
);

  import image_bit_streamer_pkg::*;

  localparam int IW = $clog2(IMG_CNT);
  localparam int RW = $clog2(ROW_W);
  localparam int BW = 2 * RW;
  localparam int AW = IW + RW;

  state_e          state_r, state_s;
  logic [BW-1:0]   bit_idx_r, bit_idx_s;
  logic [IW-1:0]   cur_img_r, cur_img_s;
  logic            din_r, din_s;
  logic            din_valid_r, din_valid_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;

  logic            ram_we_s;
  logic [ROW_W-1:0] row_data_s;
  logic            pixel_s;
  logic            last_bit_s;
  logic            last_img_s;

  // The buffer only accepts loads while no run is in flight.
  assign ram_we_s = bus.wr_en
                    && ((state_r == ST_IDLE) || (state_r == ST_DONE))
                    && (int'(bus.wr_img) < IMG_CNT);

  // {image,row} equals image*ROW_W+row because ROW_W is a power of two.
  image_row_ram #(
    .DEPTH  (IMG_CNT * ROW_W),
    .ROW_W  (ROW_W),
    .ADDR_W (AW)
  ) u_ram (
    .CLOCK_50 (CLOCK_50),
    .wr_en    (ram_we_s),
    .wr_addr  ({bus.wr_img, bus.wr_row}),
    .wr_data  (bus.wr_data),
    .rd_addr  ({cur_img_r, bit_idx_r[BW-1:RW]}),
    .rd_data  (row_data_s)
  );

  // Column 0 is the MSB; ~col == ROW_W-1-col for a power-of-two ROW_W.
  assign pixel_s    = row_data_s[~bit_idx_r[RW-1:0]];
  assign last_bit_s = (bit_idx_r == {BW{1'b1}});
  assign last_img_s = (cur_img_r == IW'(IMG_CNT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    bit_idx_s   = bit_idx_r;
    cur_img_s   = cur_img_r;
    din_s       = din_r;
    din_valid_s = din_valid_r;
    busy_s      = busy_r;
    done_s      = done_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s     = ST_STREAM;
          cur_img_s   = {IW{1'b0}};
          bit_idx_s   = {BW{1'b0}};
          din_valid_s = 1'b1;
          busy_s      = 1'b1;
          done_s      = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (bus.give_input) begin
          din_s     = pixel_s;
          bit_idx_s = bit_idx_r + {{(BW-1){1'b0}}, 1'b1};
          if (last_bit_s) begin
            state_s = ST_WAIT_RES;
          end else begin
            state_s = ST_STREAM;
          end
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_WAIT_RES: begin
        if (bus.output_valid) begin
          if (last_img_s) begin
            state_s     = ST_DONE;
            din_valid_s = 1'b0;
            busy_s      = 1'b0;
            done_s      = 1'b1;
          end else begin
            state_s   = ST_STREAM;
            cur_img_s = cur_img_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = ST_WAIT_RES;
        end
      end
      ST_DONE: begin
        if (!bus.start) begin
          state_s = ST_IDLE;
          done_s  = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        bit_idx_s   = {BW{1'b0}};
        cur_img_s   = {IW{1'b0}};
        din_s       = 1'b0;
        din_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bit_idx_r   <= {BW{1'b0}};
      cur_img_r   <= {IW{1'b0}};
      din_r       <= 1'b0;
      din_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_idx_r   <= bit_idx_s;
      cur_img_r   <= cur_img_s;
      din_r       <= din_s;
      din_valid_r <= din_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign bus.din       = din_r;
  assign bus.din_valid = din_valid_r;
  assign bus.cur_img   = cur_img_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: doc/image_bit_streamer.md
IMAGE_BIT_STREAMER -- requirements
Module: image_bit_streamer

Interface
REQ-001 Parameter IMG_CNT, default 10, number of stored test images.
REQ-002 Parameter ROW_W, default 16, pixels per row; rows per image = ROW_W; bits per image = ROW_W*ROW_W (256).
REQ-003 CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  level; run request.
REQ-006 wr_en  in  1  image-buffer row write strobe.
REQ-007 wr_img  in  clog2(IMG_CNT)  image index of write.
REQ-008 wr_row  in  clog2(ROW_W)  row index of write.
REQ-009 wr_data  in  ROW_W  row pixels; MSB = leftmost pixel.
REQ-010 give_input  in  1  downstream engine request for next pixel bit.
REQ-011 output_valid  in  1  downstream engine result strobe; current image finished.
REQ-012 din  out  1  serial pixel bit to engine.
REQ-013 din_valid  out  1  high while unprocessed images remain.
REQ-014 cur_img  out  clog2(IMG_CNT)  index of image being streamed or classified.
REQ-015 busy  out  1  high in STREAM or WAIT_RES.
REQ-016 done  out  1  high in DONE.

Function
REQ-017 Buffer SHALL hold IMG_CNT*ROW_W rows of ROW_W bits; write on wr_en only in IDLE or DONE; wr_en in other states ignored; out-of-range wr_img ignored.
REQ-018 FSM states: IDLE, STREAM, WAIT_RES, DONE.
REQ-019 IDLE -> STREAM when start=1; cur_img=0, bit_idx=0, din_valid=1.
REQ-020 STREAM: each cycle give_input=1, din SHALL register bit bit_idx of image cur_img (next cycle) and bit_idx increments; give_input=0 holds din and bit_idx.
REQ-021 Bit order: row 0 first, within row MSB first; bit_idx 0 = row 0 bit ROW_W-1, bit_idx 255 = row 15 bit 0.
REQ-022 STREAM -> WAIT_RES on the give_input cycle that issues bit_idx 255; bit_idx wraps to 0.
REQ-023 WAIT_RES: give_input ignored, din held; on output_valid=1, cur_img increments and -> STREAM, or if cur_img = IMG_CNT-1 -> DONE.
REQ-024 output_valid and give_input same cycle in WAIT_RES: output_valid acts, give_input ignored.
REQ-025 output_valid in STREAM or IDLE SHALL be ignored (no index change).
REQ-026 DONE: din_valid=0, done=1; -> IDLE when start=0; cur_img held at IMG_CNT-1.
REQ-027 start deasserted in STREAM/WAIT_RES SHALL NOT abort; run completes.
REQ-028 din latency: one CLOCK_50 cycle from give_input sample to din update.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE, din=0, din_valid=0, cur_img=0, bit_idx=0, busy=0, done=0, including mid-stream.
REQ-030 Buffer contents SHALL NOT be cleared by reset.

Structure
REQ-031 Shared package holds IMG_CNT, ROW_W, derived widths, and state encoding typedef.
REQ-032 One sub-module: image_row_ram (IMG_CNT*ROW_W x ROW_W, one write port, one combinational read port addressed by {cur_img,row}); rest in top.

Verification
REQ-033 Load image 0 row 0 = 16'hFFFF, others 0; start=1, give_input continuous -> din=1 for first 16 bits, 0 for next 240, WAIT_RES after bit 255.
REQ-034 IMG_CNT=10, ten output_valid pulses each after 256 bits -> cur_img 0..9, DONE, din_valid=0 one cycle after 10th pulse.
REQ-035 give_input toggling 1/0 -> 256 bits taken over 512 cycles, din stable in 0 cycles, sequence identical to continuous case.
REQ-036 rst=0 at bit_idx 100 of image 3 -> IDLE, all outputs 0; restart streams image 0 from bit 0 with preserved buffer.
REQ-037 output_valid pulsed mid-STREAM and coincident with give_input in WAIT_RES -> no index change in STREAM, advance in WAIT_RES.
REQ-038 wr_en during STREAM with wr_data=16'hAAAA -> buffer unchanged, streamed bits unaffected.
